// File: rtl/elink_trig_sum_scheduler.sv
// Captures one peak per channel into a one-deep slot and drains the slots onto a shared
// valid/ready link with round-robin arbitration, tagging each word with channel and window id.
module elink_trig_sum_scheduler #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned MULTISAMPLE = 8,
    parameter int unsigned DATA_W      = 13,
    parameter int unsigned THRESH      = 1,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic [NUM_CH*DATA_W-1:0] sum_in_i,
    input  logic                     clear_ovf_i,
    input  logic                     out_ready_i,
    output logic                     out_valid_o,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [CH_W-1:0]          out_ch_o,
    output logic [7:0]               out_win_o,
    output logic [NUM_CH-1:0]        ovf_o,
    output logic [7:0]               drop_cnt_o,
    output logic                     busy_o
);

    localparam int unsigned PH_W = (MULTISAMPLE > 1) ? $clog2(MULTISAMPLE) : 1;
    localparam logic [PH_W-1:0] PhaseLast = PH_W'(MULTISAMPLE - 1);
    localparam logic [DATA_W-1:0] ThreshW = DATA_W'(THRESH);
    localparam logic [CH_W-1:0] RrReset = CH_W'(NUM_CH - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e state_q, state_d;

    logic [PH_W-1:0]   win_phase_q, win_phase_d;
    logic [7:0]        window_id_q, window_id_d;
    logic [CH_W-1:0]   rr_q, rr_d;

    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [DATA_W-1:0] pend_data_q [NUM_CH];
    logic [7:0]        pend_win_q  [NUM_CH];

    logic [DATA_W-1:0] out_data_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [7:0]        out_win_q;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic              out_valid;
    logic              load_out;
    logic              gnt_found;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W-1:0]   cand_ch;
    logic [NUM_CH-1:0] gnt_vec;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] capture;
    logic [NUM_CH-1:0] drop;
    logic [7:0]        ndrop;
    logic [8:0]        drop_sum;
    logic [DATA_W-1:0] sum_ch [NUM_CH];

    // ---------------- window counters ----------------
    always_comb begin
        win_phase_d = win_phase_q + PH_W'(1);
        window_id_d = window_id_q;
        if (win_phase_q == PhaseLast) begin
            win_phase_d = '0;
            window_id_d = window_id_q + 8'd1;
        end
    end

    // ---------------- hit detection ----------------
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sum_ch[i] = sum_in_i[i*DATA_W +: DATA_W];
            hit[i]    = enable_i && (sum_ch[i] != '0) && (sum_ch[i] >= ThreshW);
        end
    end

    // ---------------- round-robin grant ----------------
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_ch   = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand_ch = CH_W'((32'(rr_q) + k) % NUM_CH);
            if (!gnt_found && pend_q[cand_ch]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_ch;
            end
        end
        load_out = (!out_valid || out_ready_i) && gnt_found;
        gnt_vec  = '0;
        if (load_out) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
        rr_d = load_out ? gnt_idx : rr_q;
    end

    // ---------------- slot capture / drop ----------------
    // A slot being granted this cycle is free for a new capture at the same edge.
    always_comb begin
        ndrop = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            capture[i] = hit[i] && (!pend_q[i] || gnt_vec[i]);
            drop[i]    = hit[i] && pend_q[i] && !gnt_vec[i];
            pend_d[i]  = capture[i] || (pend_q[i] && !gnt_vec[i]);
            ndrop      = ndrop + 8'(drop[i]);
        end
    end

    // ---------------- overflow flags and saturating drop counter ----------------
    always_comb begin
        ovf_d      = (clear_ovf_i ? '0 : ovf_q) | drop;
        drop_sum   = {1'b0, (clear_ovf_i ? 8'd0 : drop_cnt_q)} + {1'b0, ndrop};
        drop_cnt_d = drop_sum[8] ? 8'hff : drop_sum[7:0];
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (|pend_q) state_d = StSend;
            StSend: if (out_ready_i && !(|pend_q)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid = (state_q == StSend);
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_phase_q <= '0;
            window_id_q <= '0;
            rr_q        <= RrReset;
            pend_q      <= '0;
            ovf_q       <= '0;
            drop_cnt_q  <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_win_q   <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                pend_data_q[i] <= '0;
                pend_win_q[i]  <= '0;
            end
        end else begin
            win_phase_q <= win_phase_d;
            window_id_q <= window_id_d;
            rr_q        <= rr_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            drop_cnt_q  <= drop_cnt_d;
            if (load_out) begin
                out_data_q <= pend_data_q[gnt_idx];
                out_ch_q   <= gnt_idx;
                out_win_q  <= pend_win_q[gnt_idx];
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (capture[i]) begin
                    pend_data_q[i] <= sum_ch[i];
                    pend_win_q[i]  <= window_id_q;
                end
            end
        end
    end

    assign out_valid_o = out_valid;
    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;
    assign out_win_o   = out_win_q;
    assign ovf_o       = ovf_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign busy_o      = (|pend_q) || out_valid;

endmodule
